spi_modport: RTL and testbench

//  Single-byte SPI master, mode 0 (CPOL=0, CPHA=0), MSB first, one chip select.
//  - A start pulse sends tx_data on mosi and captures 8 bits from miso into rx_data.
//  - Reports progress with busy and a one-cycle done pulse.
//  - Sits between a local controller and one external SPI slave.

---
 rtl/spi_modport.sv | 102 ++++++++++
 tb/tb_spi_modport.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/spi_modport.sv
// spi_modport: single-byte SPI master, mode 0, MSB first, one chip select.
// Two-process FSM: registers below, next-state/output logic in always_comb.
module spi_modport #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       done,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso,
    output logic       cs_n
);
    localparam int H  = CLK_DIV / 2;
    localparam int DW = (H > 1) ? $clog2(H) : 1;

    typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

    state_t          state, state_nx;
    logic [7:0]      tx_reg, tx_nx, rx_reg, rx_nx, rx_data_nx;
    logic [DW-1:0]   div_cnt, div_nx;
    logic [3:0]      bit_cnt, bit_nx;
    logic            sclk_nx, mosi_nx, cs_nx, busy_nx, done_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tx_reg  <= '0;
            rx_reg  <= '0;
            rx_data <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            cs_n    <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nx;
            tx_reg  <= tx_nx;
            rx_reg  <= rx_nx;
            rx_data <= rx_data_nx;
            div_cnt <= div_nx;
            bit_cnt <= bit_nx;
            sclk    <= sclk_nx;
            mosi    <= mosi_nx;
            cs_n    <= cs_nx;
            busy    <= busy_nx;
            done    <= done_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        tx_nx      = tx_reg;
        rx_nx      = rx_reg;
        rx_data_nx = rx_data;
        div_nx     = div_cnt;
        bit_nx     = bit_cnt;
        sclk_nx    = sclk;
        mosi_nx    = mosi;
        cs_nx      = cs_n;
        busy_nx    = busy;
        done_nx    = 1'b0;
        if (state == IDLE) begin
            if (start) begin
                state_nx = XFER;
                tx_nx    = tx_data;
                mosi_nx  = tx_data[7];
                cs_nx    = 1'b0;
                busy_nx  = 1'b1;
                div_nx   = '0;
                bit_nx   = '0;
            end
        end else if (div_cnt == DW'(H - 1)) begin
            div_nx  = '0;
            sclk_nx = ~sclk;
            // rising edge samples miso; falling edge advances mosi or ends the byte
            if (!sclk) begin
                rx_nx  = {rx_reg[6:0], miso};
                bit_nx = bit_cnt + 4'd1;
            end else if (bit_cnt != 4'd8) begin
                tx_nx   = {tx_reg[6:0], 1'b0};
                mosi_nx = tx_reg[6];
            end else begin
                state_nx   = IDLE;
                sclk_nx    = 1'b0;
                cs_nx      = 1'b1;
                busy_nx    = 1'b0;
                mosi_nx    = 1'b0;
                done_nx    = 1'b1;
                rx_data_nx = rx_reg;
            end
        end else begin
            div_nx = div_cnt + DW'(1);
        end
    end
endmodule

// File: tb/tb_spi_modport.sv
// tb_spi_modport: randomized self-checking bench for spi_modport (CLK_DIV=4)
// with a loopback / tied / byte-shifting slave model on miso.
module tb_spi_modport;
    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [7:0] rx_data;
    logic       busy, done, sclk, mosi, miso, cs_n;

    int total = 0;
    int bad = 0;

    // miso source: 0 loopback, 1 tied high, 2 tied low, 3 slave shift register
    int         mode = 0;
    logic [7:0] slave_byte = 8'h00;
    logic [7:0] sl_sh = 8'h00;
    logic [7:0] sl_cap = 8'h00;

    // observations of the last transfer
    int         busy_cyc, rises, done_cnt, done_at_fall, timed_out;
    logic [7:0] mosi_bits;

    spi_modport #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tx_data(tx_data),
        .rx_data(rx_data), .busy(busy), .done(done), .sclk(sclk),
        .mosi(mosi), .miso(miso), .cs_n(cs_n)
    );

    always #5 clk = ~clk;

    assign miso = (mode == 0) ? mosi : (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : sl_sh[7];

    always @(negedge cs_n) begin
        sl_sh  = slave_byte;
        sl_cap = 8'h00;
    end
    always @(negedge sclk) if (!cs_n) sl_sh = {sl_sh[6:0], 1'b0};
    always @(posedge sclk) sl_cap = {sl_cap[6:0], mosi};

    task automatic run_xfer(input logic [7:0] tx, input int glitch_at);
        int   n;
        logic prev;
        start = 1'b1;
        tx_data = tx;
        @(negedge clk);
        start = 1'b0;
        tx_data = 8'($urandom);
        busy_cyc = 0; rises = 0; done_cnt = 0; mosi_bits = 8'h00; n = 0;
        prev = sclk;
        while (busy && n < 200) begin
            if (sclk && !prev) begin
                rises++;
                mosi_bits = {mosi_bits[6:0], mosi};
            end
            prev = sclk;
            busy_cyc++;
            if (done) done_cnt++;
            if (n == glitch_at) begin
                start = 1'b1;
                tx_data = 8'hFF;
            end else start = 1'b0;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        timed_out = busy ? 1 : 0;
        done_at_fall = done ? 1 : 0;
        done_cnt += done_at_fall;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        total++; if (sclk !== 1'b0 || cs_n !== 1'b1 || mosi !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rx_data !== 8'h00) begin
            bad++; $display("FAIL reset: sclk=%b cs_n=%b mosi=%b busy=%b done=%b rx=%h, required 0 1 0 0 0 00", sclk, cs_n, mosi, busy, done, rx_data);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0 || cs_n !== 1'b1) begin
            bad++; $display("FAIL idle_after_reset: busy=%b cs_n=%b, required 0 1", busy, cs_n);
        end
    endtask

    task automatic test_loopback(input logic [7:0] tx);
        mode = 0;
        run_xfer(tx, -1);
        total++; if (timed_out != 0) begin bad++; $display("FAIL loop_timeout: busy stuck for tx=%h", tx); end
        total++; if (busy_cyc != 8 * CLK_DIV) begin bad++; $display("FAIL loop_busy_len: got %0d, required %0d", busy_cyc, 8 * CLK_DIV); end
        total++; if (rises != 8) begin bad++; $display("FAIL loop_sclk_pulses: got %0d, required 8", rises); end
        total++; if (mosi_bits !== tx) begin bad++; $display("FAIL loop_mosi_bits: got %h, required %h", mosi_bits, tx); end
        total++; if (done_at_fall != 1 || done_cnt != 1) begin bad++; $display("FAIL loop_done: at_fall=%0d count=%0d, required 1 1", done_at_fall, done_cnt); end
        total++; if (rx_data !== tx) begin bad++; $display("FAIL loop_rx: got %h, required %h", rx_data, tx); end
    endtask

    task automatic test_tied;
        mode = 1;
        run_xfer(8'h00, -1);
        total++; if (rx_data !== 8'hFF) begin bad++; $display("FAIL tied_high_rx: got %h, required ff", rx_data); end
        total++; if (mosi_bits !== 8'h00) begin bad++; $display("FAIL tied_high_mosi: got %h, required 00", mosi_bits); end
        mode = 2;
        run_xfer(8'h00, -1);
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL tied_low_rx: got %h, required 00", rx_data); end
    endtask

    task automatic test_slave(input logic [7:0] tx, input logic [7:0] sb);
        mode = 3;
        slave_byte = sb;
        run_xfer(tx, -1);
        total++; if (rx_data !== sb) begin bad++; $display("FAIL slave_rx: got %h, required %h (tx %h)", rx_data, sb, tx); end
        total++; if (sl_cap !== tx) begin bad++; $display("FAIL slave_capture: got %h, required %h", sl_cap, tx); end
    endtask

    task automatic test_ignore_start;
        mode = 0;
        run_xfer(8'h3C, 10);
        total++; if (mosi_bits !== 8'h3C) begin bad++; $display("FAIL ignore_mosi: got %h, required 3c", mosi_bits); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL ignore_done_count: got %0d, required 1", done_cnt); end
        total++; if (busy_cyc != 8 * CLK_DIV) begin bad++; $display("FAIL ignore_busy_len: got %0d, required %0d", busy_cyc, 8 * CLK_DIV); end
        total++; if (rx_data !== 8'h3C) begin bad++; $display("FAIL ignore_rx: got %h, required 3c", rx_data); end
    endtask

    task automatic test_back_to_back;
        int n = 0;
        mode = 0;
        start = 1'b1;
        tx_data = 8'h96;
        @(negedge clk);
        while (!done && n < 200) begin @(negedge clk); n++; end
        total++; if (!done || busy !== 1'b0) begin bad++; $display("FAIL b2b_done_cycle: done=%b busy=%b, required 1 0", done, busy); end
        @(negedge clk);
        start = 1'b0;
        total++; if (busy !== 1'b1 || cs_n !== 1'b0) begin bad++; $display("FAIL b2b_restart: busy=%b cs_n=%b, required 1 0", busy, cs_n); end
        n = 0;
        while (!done && n < 200) begin @(negedge clk); n++; end
        total++; if (rx_data !== 8'h96) begin bad++; $display("FAIL b2b_rx: got %h, required 96", rx_data); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int   n = 0, r = 0, dn = 0;
        logic prev;
        mode = 0;
        start = 1'b1;
        tx_data = 8'h5A;
        @(negedge clk);
        start = 1'b0;
        prev = sclk;
        while (r < 3 && n < 200) begin
            @(negedge clk);
            if (sclk && !prev) r++;
            prev = sclk;
            n++;
        end
        #1 rst_n = 1'b0;
        #1;
        total++; if (cs_n !== 1'b1 || busy !== 1'b0 || rx_data !== 8'h00 || sclk !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL reset_mid: cs_n=%b busy=%b rx=%h sclk=%b done=%b, required 1 0 00 0 0", cs_n, busy, rx_data, sclk, done);
        end
        repeat (3) begin @(negedge clk); if (done) dn++; end
        rst_n = 1'b1;
        repeat (40) begin @(negedge clk); if (done) dn++; end
        total++; if (dn != 0 || rx_data !== 8'h00) begin bad++; $display("FAIL reset_mid_no_done: dones=%0d rx=%h, required 0 00", dn, rx_data); end
        test_loopback(8'hC7);
    endtask

    initial begin
        test_reset();
        test_loopback(8'hA5);
        test_tied();
        test_slave(8'h3C, 8'hC3);
        for (int i = 0; i < 4; i++) test_slave(8'($urandom), 8'($urandom));
        for (int i = 0; i < 3; i++) test_loopback(8'($urandom));
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
